// File: rtl/mcu_irq_pkg.sv
// Shared constants and types for the MCU interrupt collector.
// Command code, byte indices within command 6, and the scheduler state encoding.
package mcu_irq_pkg;

  localparam logic [7:0] CMD_IRQ    = 8'd6;
  localparam logic [3:0] IDX_MASK   = 4'd1;
  localparam logic [3:0] IDX_MASKRD = 4'd2;
  localparam logic [3:0] IDX_OVF    = 4'd3;
  localparam logic [3:0] IDX_MAX    = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } irq_state_t;

  function automatic logic [3:0] idx_inc(input logic [3:0] idx);
    return (idx == IDX_MAX) ? IDX_MAX : idx + 4'd1;
  endfunction

endpackage

// File: rtl/mcu_irq_src_latch.sv
// One event source: rising-edge detect, pending bit, optional overflow bit (MCU_IRQ_OVERFLOW_EN).
// Latency: pending sets one edge after the event edge; no backpressure, events are never stalled.
module mcu_irq_src_latch
  import mcu_irq_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic src_evt,
  input  logic ack_edge,
  input  logic ovf_clr,
  output logic pending,
  output logic ovf
);

  logic armed_q, armed_d;
  logic src_q, src_d;
  logic pending_q, pending_d;
  logic evt;

  // armed_q suppresses a false edge from a source already high at reset release
  always_comb begin
    armed_d   = 1'b1;
    src_d     = src_evt;
    evt       = armed_q & src_evt & ~src_q;
    pending_d = evt | (pending_q & ~ack_edge);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= 1'b0;
      src_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      src_q     <= src_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifdef MCU_IRQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // a new overflow on the read edge wins over the clear
  always_comb begin
    ovf_d = (evt & pending_q & ~ack_edge) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mcu_irq_ctrl.sv
// Interrupt collector/scheduler with command-6 snoop and idle holdoff; overflow tracking under MCU_IRQ_OVERFLOW_EN.
// Latency: event edge to int_in is two edges from IDLE, one in ACTIVE; no backpressure, bytes and events always accepted.
module mcu_irq_ctrl
  import mcu_irq_pkg::*;
#(
  parameter int NUM_SRC = 7,
  parameter int HOLDOFF = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_in_strobe,
  input  logic               data_in_start,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               data_out_sel,
  input  logic [NUM_SRC-1:0] src_event,
  input  logic [7:0]         int_ack,
  output logic [7:0]         int_in
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  logic [7:1]         ack_q, ack_d;
  logic [NUM_SRC-1:0] ack_edge;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] ovf;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               ovf_clr;
  irq_state_t         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               sel_q, sel_d;
  logic [7:0]         dout_q, dout_d;
  logic               act;
  logic [7:0]         int_vec, pend_ext, mask_ext, ovf_ext;
  logic               unused_ack0;

  assign unused_ack0 = int_ack[0];

  always_comb begin
    ack_d    = int_ack[7:1];
    ack_edge = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_edge[i] = int_ack[i+1] & ~ack_q[i+1];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    mcu_irq_src_latch u_latch (
      .clk      (clk),
      .reset_n  (reset_n),
      .src_evt  (src_event[i]),
      .ack_edge (ack_edge[i]),
      .ovf_clr  (ovf_clr),
      .pending  (pending[i]),
      .ovf      (ovf[i])
    );
  end

  // Command snoop: index 0 is the command byte, data bytes count up and stick at 15
  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    ovf_ext  = '0;
    pend_ext[NUM_SRC-1:0] = pending;
    mask_ext[NUM_SRC-1:0] = mask_q;
    ovf_ext[NUM_SRC-1:0]  = ovf;

    idx_d   = idx_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    mask_d  = mask_q;
    ovf_clr = 1'b0;
    if (data_in_strobe) begin
      if (data_in_start) begin
        idx_d = '0;
        sel_d = (data_in == CMD_IRQ);
      end else begin
        idx_d = idx_inc(idx_q);
        if (sel_q) begin
          case (idx_d)
            IDX_MASK: begin
              mask_d = data_in[NUM_SRC-1:0];
              dout_d = pend_ext;
            end
            IDX_MASKRD: dout_d = mask_ext;
            IDX_OVF: begin
              dout_d  = ovf_ext;
              ovf_clr = 1'b1;
            end
            default: dout_d = 8'h00;
          endcase
        end
      end
    end
  end

  // Scheduler: int_in is forced low for HOLDOFF cycles after the last enabled source clears
  always_comb begin
    act     = |(pending & mask_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    int_vec = '0;
    case (state_q)
      IDLE: begin
        if (act) state_d = ACTIVE;
      end
      ACTIVE: begin
        int_vec[NUM_SRC:1] = pending & mask_q;
        if (!act) begin
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= '0;
      mask_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      ack_q   <= ack_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign int_in       = int_vec;
  assign data_out     = dout_q;
  assign data_out_sel = sel_q;

endmodule

// File: tb/tb_mcu_irq_ctrl.sv
// Directed bench for mcu_irq_ctrl: vector table for single-cycle behaviour, hand sequences for holdoff, masking, overflow and reset.
module tb_mcu_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_sel;
  logic [6:0] src_event;
  logic [7:0] int_ack;
  logic [7:0] int_in;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef MCU_IRQ_OVERFLOW_EN
  localparam logic [7:0] EXP_OVF = 8'h02;
`else
  localparam logic [7:0] EXP_OVF = 8'h00;
`endif

  mcu_irq_ctrl #(.NUM_SRC(7), .HOLDOFF(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_sel   (data_out_sel),
    .src_event      (src_event),
    .int_ack        (int_ack),
    .int_in         (int_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic       start;
    logic [7:0] din;
    logic [6:0] src;
    logic [7:0] ack;
    logic [7:0] e_int;
    logic [7:0] e_dout;
    logic       e_sel;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic byte_cyc(input logic start, input logic [7:0] din);
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = din;
    tick();
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //         stb   start din    src    ack    int    dout   sel
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 7'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h06, 7'h00, 8'h00, 8'h08, 8'h00, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 8'h7F, 7'h00, 8'h00, 8'h08, 8'h04, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 7'h00, 8'h00, 8'h08, 8'h7F, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 7'h00, 8'h00, 8'h08, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'hAA, 7'h00, 8'h00, 8'h08, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 7'h01, 8'h00, 8'h0A, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 7'h00, 8'h02, 8'h08, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 8'h08, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 7'h01, 8'h02, 8'h0A, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 7'h00, 8'h02, 8'h0A, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'h06, 7'h00, 8'h02, 8'h0A, 8'h00, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 8'h7F, 7'h00, 8'h02, 8'h0A, 8'h05, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 8'h05, 7'h00, 8'h02, 8'h0A, 8'h05, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 7'h00, 8'h02, 8'h0A, 8'h05, 1'b0};

    reset_n        = 1'b0;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = 8'h00;
    src_event      = '0;
    int_ack        = 8'h00;
    #12;
    chk("reset int_in", int_in, 8'h00);
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_out_sel", {7'b0, data_out_sel}, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < NVEC; i++) begin
      data_in_strobe = tbl[i].stb;
      data_in_start  = tbl[i].start;
      data_in        = tbl[i].din;
      src_event      = tbl[i].src;
      int_ack        = tbl[i].ack;
      tick();
      chk($sformatf("vec%0d int_in", i), int_in, tbl[i].e_int);
      chk($sformatf("vec%0d data_out", i), data_out, tbl[i].e_dout);
      chk($sformatf("vec%0d data_out_sel", i), {7'b0, data_out_sel}, {7'b0, tbl[i].e_sel});
    end
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = 8'h00;

    // Ack the last sources, keep ack held, new event 3 cycles later: 16 HOLD cycles then IDLE then ACTIVE
    int_ack = 8'h00;
    tick();
    int_ack = 8'h0A;
    tick();
    chk("holdoff k0 int_in", int_in, 8'h00);
    for (int k = 1; k <= 18; k++) begin
      src_event = (k == 3) ? 7'h04 : 7'h00;
      tick();
      chk($sformatf("holdoff k%0d int_in", k), int_in, (k == 18) ? 8'h08 : 8'h00);
    end
    src_event = '0;

    // Mask everything through command 6 while source 4 is pending
    src_event = 7'h10;
    tick();
    chk("src4 add int_in", int_in, 8'h28);
    src_event = 7'h00;
    int_ack   = 8'h02;
    tick();
    int_ack = 8'h0A;
    tick();
    chk("src2 acked int_in", int_in, 8'h20);
    byte_cyc(1'b1, 8'h06);
    chk("mask cmd sel", {7'b0, data_out_sel}, 8'h01);
    for (int k = 0; k <= 18; k++) begin
      case (k)
        0:       byte_cyc(1'b0, 8'h00);
        1:       byte_cyc(1'b0, 8'h00);
        2:       byte_cyc(1'b1, 8'h06);
        3:       byte_cyc(1'b0, 8'h7F);
        default: tick();
      endcase
      if (k == 0) chk("mask0 byte1 data_out", data_out, 8'h10);
      if (k == 1) chk("mask0 byte2 data_out", data_out, 8'h00);
      if (k == 3) chk("mask restore byte1 data_out", data_out, 8'h10);
      chk($sformatf("mask k%0d int_in", k), int_in, (k == 18) ? 8'h20 : 8'h00);
    end

    // Two events on source 1 without an ack
    src_event = 7'h02;
    tick();
    src_event = 7'h00;
    tick();
    src_event = 7'h02;
    tick();
    src_event = 7'h00;
    tick();
    chk("ovf int_in", int_in, 8'h24);
    byte_cyc(1'b1, 8'h06);
    byte_cyc(1'b0, 8'h7F);
    byte_cyc(1'b0, 8'h00);
    byte_cyc(1'b0, 8'h00);
    chk("ovf first read", data_out, EXP_OVF);
    byte_cyc(1'b1, 8'h06);
    byte_cyc(1'b0, 8'h7F);
    byte_cyc(1'b0, 8'h00);
    byte_cyc(1'b0, 8'h00);
    chk("ovf second read", data_out, 8'h00);
    for (int k = 4; k <= 17; k++) byte_cyc(1'b0, 8'h00);
    chk("saturated idx data_out", data_out, 8'h00);
    chk("saturated idx int_in", int_in, 8'h24);

    // Asynchronous reset mid-operation, source 0 held high through release
    byte_cyc(1'b1, 8'h06);
    byte_cyc(1'b0, 8'h0F);
    chk("pre-reset byte1 data_out", data_out, 8'h12);
    chk("pre-reset masked int_in", int_in, 8'h04);
    src_event = 7'h01;
    tick();
    chk("pre-reset src0 int_in", int_in, 8'h06);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset int_in", int_in, 8'h00);
    chk("async reset data_out", data_out, 8'h00);
    chk("async reset data_out_sel", {7'b0, data_out_sel}, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("held src after reset int_in", int_in, 8'h00);
    src_event = 7'h41;
    tick();
    tick();
    chk("post-reset mask all-ones int_in", int_in, 8'h80);
    byte_cyc(1'b1, 8'h06);
    byte_cyc(1'b0, 8'h7F);
    chk("post-reset pending data_out", data_out, 8'h40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
